// File: rtl/branch_predict_unit_if.sv
`default_nettype none
// ============================================================================
//  branch_predict_unit_if
//  Fetch-lookup and decode-resolution signal bundle for branch_predict_unit.
//  Optional BPU_STATS_EN adds the BrCount/MissCount statistics outputs.
//  Revision: 1.0
// ============================================================================
interface branch_predict_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] IFPC;
  logic            PredTaken;
  logic            DEBE;
  logic            DEStall;
  logic [2:0]      DEBS;
  logic [XLEN-1:0] DEPC;
  logic [12:0]     DEImm;
  logic [XLEN-1:0] RRS1;
  logic [XLEN-1:0] RRS2;
  logic            DEPredTaken;
  logic            DEBranchFlush;
  logic [XLEN-1:0] RedirectPC;
`ifdef BPU_STATS_EN
  logic [31:0]     BrCount;
  logic [31:0]     MissCount;
`endif

  modport master (
    output IFPC, DEBE, DEStall, DEBS, DEPC, DEImm, RRS1, RRS2, DEPredTaken,
`ifdef BPU_STATS_EN
    input  BrCount, MissCount,
`endif
    input  PredTaken, DEBranchFlush, RedirectPC
  );

  modport slave (
    input  IFPC, DEBE, DEStall, DEBS, DEPC, DEImm, RRS1, RRS2, DEPredTaken,
`ifdef BPU_STATS_EN
    output BrCount, MissCount,
`endif
    output PredTaken, DEBranchFlush, RedirectPC
  );
endinterface
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  branch_predict_unit
//  2-bit saturating-counter BHT with decode-stage resolution and one-cycle
//  registered mispredict flush. Define BPU_STATS_EN for branch/miss counters.
//  Revision: 1.0
// ============================================================================
module branch_predict_unit #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 16,
  parameter logic [1:0] CTR_INIT    = 2'b01
) (
  input  wire logic            CLK,
  input  wire logic            rst_n,
  branch_predict_unit_if.slave bus
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];
  logic             flush_q, flush_d;
  logic [XLEN-1:0]  redirect_q, redirect_d;
  logic [IDX_W-1:0] if_idx, de_idx;
  logic             is_branch, taken, resolve, mispredict;
  logic [XLEN-1:0]  target, fall_through;
  logic             unused_bits;

  assign if_idx      = bus.IFPC[IDX_W+1:2];
  assign de_idx      = bus.DEPC[IDX_W+1:2];
  assign unused_bits = ^{bus.IFPC[XLEN-1:IDX_W+2], bus.IFPC[1:0], bus.DEImm[0]};

  // Table read uses the registered state, so a same-index update is not visible yet
  assign bus.PredTaken = bht_q[if_idx][1];

  always_comb begin
    taken     = 1'b0;
    is_branch = 1'b1;
    case (bus.DEBS)
      3'b000:  taken = (bus.RRS1 == bus.RRS2);
      3'b001:  taken = (bus.RRS1 != bus.RRS2);
      3'b100:  taken = ($signed(bus.RRS1) <  $signed(bus.RRS2));
      3'b101:  taken = ($signed(bus.RRS1) >= $signed(bus.RRS2));
      3'b110:  taken = (bus.RRS1 <  bus.RRS2);
      3'b111:  taken = (bus.RRS1 >= bus.RRS2);
      default: is_branch = 1'b0;
    endcase
  end

  // While a flush is out, the DE slot holds a wrong-path instruction
  assign resolve      = bus.DEBE && !bus.DEStall && !flush_q && is_branch;
  assign mispredict   = resolve && (taken != bus.DEPredTaken);
  assign target       = bus.DEPC + {{(XLEN-13){bus.DEImm[12]}}, bus.DEImm[12:1], 1'b0};
  assign fall_through = bus.DEPC + XLEN'(4);

  always_comb begin
    bht_d      = bht_q;
    flush_d    = mispredict;
    redirect_d = redirect_q;
    if (resolve) begin
      if (taken && (bht_q[de_idx] != 2'b11)) begin
        bht_d[de_idx] = bht_q[de_idx] + 2'd1;
      end else if (!taken && (bht_q[de_idx] != 2'b00)) begin
        bht_d[de_idx] = bht_q[de_idx] - 2'd1;
      end
    end
    if (mispredict) begin
      redirect_d = taken ? target : fall_through;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= CTR_INIT;
      end
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      bht_q      <= bht_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
    end
  end

  assign bus.DEBranchFlush = flush_q;
  assign bus.RedirectPC    = redirect_q;

`ifdef BPU_STATS_EN
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    br_count_d   = br_count_q;
    miss_count_d = miss_count_q;
    if (resolve && (br_count_q != 32'hFFFF_FFFF)) begin
      br_count_d = br_count_q + 32'd1;
    end
    if (mispredict && (miss_count_q != 32'hFFFF_FFFF)) begin
      miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else begin
      br_count_q   <= br_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign bus.BrCount   = br_count_q;
  assign bus.MissCount = miss_count_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  tb_branch_predict_unit
//  Directed stimulus with a per-cycle expectation queue drained by a monitor.
//  Revision: 1.0
// ============================================================================
module tb_branch_predict_unit;
  localparam int XLEN = 32;

  logic CLK   = 1'b0;
  logic rst_n = 1'b0;
  always #5 CLK = ~CLK;

  branch_predict_unit_if #(.XLEN(XLEN)) bus ();

  branch_predict_unit #(
    .XLEN        (XLEN),
    .BHT_ENTRIES (16),
    .CTR_INIT    (2'b01)
  ) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic        cp;   // check prediction
    logic        ep;
    logic        ef;
    logic [31:0] er;
    logic        cs;   // check statistics
    logic [31:0] eb;
    logic [31:0] em;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: one expectation describes the outputs seen in one clock cycle
  always @(negedge CLK) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (bus.DEBranchFlush !== e.ef) begin
        n_bad++;
        $display("FAIL %s flush: got %0b want %0b", e.name, bus.DEBranchFlush, e.ef);
      end
      n_cmp++;
      if (bus.RedirectPC !== e.er) begin
        n_bad++;
        $display("FAIL %s redirect: got %08h want %08h", e.name, bus.RedirectPC, e.er);
      end
      if (e.cp) begin
        n_cmp++;
        if (bus.PredTaken !== e.ep) begin
          n_bad++;
          $display("FAIL %s pred: got %0b want %0b", e.name, bus.PredTaken, e.ep);
        end
      end
`ifdef BPU_STATS_EN
      if (e.cs) begin
        n_cmp++;
        if ((bus.BrCount !== e.eb) || (bus.MissCount !== e.em)) begin
          n_bad++;
          $display("FAIL %s stats: got %0d/%0d want %0d/%0d", e.name,
                   bus.BrCount, bus.MissCount, e.eb, e.em);
        end
      end
`endif
    end
  end

  task automatic push(input string name, input logic cp, input logic ep,
                      input logic ef, input logic [31:0] er,
                      input logic cs = 1'b0, input logic [31:0] eb = 32'd0,
                      input logic [31:0] em = 32'd0);
    exp_t e;
    e.name = name; e.cp = cp; e.ep = ep; e.ef = ef; e.er = er;
    e.cs = cs; e.eb = eb; e.em = em;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic br(input logic [2:0] bs, input logic [31:0] pc, input logic [12:0] imm,
                    input logic [31:0] a, input logic [31:0] b, input logic pt);
    bus.DEBE        = 1'b1;
    bus.DEBS        = bs;
    bus.DEPC        = pc;
    bus.DEImm       = imm;
    bus.RRS1        = a;
    bus.RRS2        = b;
    bus.DEPredTaken = pt;
  endtask

  task automatic idle();
    bus.DEBE    = 1'b0;
    bus.DEStall = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.IFPC = '0; bus.DEBE = 1'b0; bus.DEStall = 1'b0; bus.DEBS = 3'b000;
    bus.DEPC = '0; bus.DEImm = '0; bus.RRS1 = '0; bus.RRS2 = '0;
    bus.DEPredTaken = 1'b0;
    tick();

    // Reset state
    bus.IFPC = 32'h4;
    push("rst_state", 1, 0, 0, 32'h0, 1, 32'd0, 32'd0); tick();
    rst_n = 1'b1;
    push("rst_release", 1, 0, 0, 32'h0); tick();

    // BEQ taken at PC 4, offset -8, predicted not-taken
    br(3'b000, 32'h4, 13'h1FF8, 32'h10, 32'h10, 1'b0);
    push("c1_lookup", 1, 0, 0, 32'h0); tick();
    push("c2_flush_neg", 1, 1, 1, 32'hFFFF_FFFC); tick();
    push("c3_resolve", 1, 1, 0, 32'hFFFF_FFFC); tick();
    push("c4_flush", 1, 1, 1, 32'hFFFF_FFFC); tick();
    push("c5_sat", 1, 1, 0, 32'hFFFF_FFFC); tick();
    push("c6_flush", 1, 1, 1, 32'hFFFF_FFFC); tick();
    br(3'b000, 32'h4, 13'h1FF8, 32'h10, 32'h11, 1'b1);
    push("c7_nt", 1, 1, 0, 32'hFFFF_FFFC); tick();
    idle();
    push("c8_flush_ft", 1, 1, 1, 32'h8); tick();
    push("c9_hold", 1, 1, 0, 32'h8); tick();

    // Signed vs unsigned compare on the same operands
    br(3'b100, 32'h20, 13'h0010, 32'hFFFF_FFFF, 32'h1, 1'b1);
    bus.IFPC = 32'h20;
    push("c10_blt", 1, 0, 0, 32'h8); tick();
    br(3'b110, 32'h20, 13'h0010, 32'hFFFF_FFFF, 32'h1, 1'b1);
    push("c11_bltu", 1, 1, 0, 32'h8); tick();
    idle();
    push("c12_flush_ft", 1, 0, 1, 32'h24); tick();

    // GE / NE / GEU and the non-branch funct3 codes
    br(3'b101, 32'hC, 13'h0100, 32'h5, 32'h5, 1'b0);
    bus.IFPC = 32'hC;
    push("c13_bge", 1, 0, 0, 32'h24); tick();
    br(3'b001, 32'hC, 13'h0100, 32'h5, 32'h5, 1'b1);
    push("c14_wrongpath", 1, 1, 1, 32'h10C); tick();
    br(3'b111, 32'hC, 13'h0100, 32'h1, 32'hFFFF_FFFF, 1'b0);
    push("c15_bgeu", 1, 1, 0, 32'h10C); tick();
    br(3'b001, 32'hC, 13'h0100, 32'h1, 32'h2, 1'b1);
    push("c16_bne", 1, 0, 0, 32'h10C); tick();
    br(3'b010, 32'hC, 13'h0100, 32'h1, 32'h2, 1'b1);
    push("c17_f010", 1, 1, 0, 32'h10C); tick();
    br(3'b011, 32'hC, 13'h0100, 32'h1, 32'h1, 1'b0);
    push("c18_f011", 1, 1, 0, 32'h10C); tick();
    idle();
    push("c19_nochange", 1, 1, 0, 32'h10C); tick();

    // Stall holds resolution for three cycles
    br(3'b000, 32'h10, 13'h0008, 32'h7, 32'h7, 1'b0);
    bus.DEStall = 1'b1;
    bus.IFPC    = 32'h10;
    for (int i = 0; i < 3; i++) begin
      push("stall", 1, 0, 0, 32'h10C); tick();
    end
    bus.DEStall = 1'b0;
    push("c23_unstall", 1, 0, 0, 32'h10C); tick();
    idle();
    push("c24_flush", 1, 1, 1, 32'h18); tick();
    push("c25_idle", 1, 1, 0, 32'h18); tick();

    // Reset during a flush cycle
    br(3'b000, 32'h14, 13'h0040, 32'h3, 32'h3, 1'b0);
    bus.IFPC = 32'h4;
    push("c26_mispredict", 1, 1, 0, 32'h18); tick();
    rst_n = 1'b0;
    push("c27_rst_in_flush", 1, 0, 0, 32'h0, 1, 32'd0, 32'd0); tick();
    bus.IFPC = 32'h10;
    push("c28_ctr_init", 1, 0, 0, 32'h0); tick();
    rst_n = 1'b1;
    br(3'b000, 32'h14, 13'h0040, 32'h3, 32'h3, 1'b0);
    bus.IFPC = 32'h14;
    push("c29_first_res", 1, 0, 0, 32'h0); tick();
    idle();
    push("c30_flush", 1, 1, 1, 32'h54); tick();
    push("c31_hold", 1, 1, 0, 32'h54); tick();

    // Fall-through wraps modulo 2^XLEN
    br(3'b000, 32'hFFFF_FFFC, 13'h0000, 32'h0, 32'h1, 1'b1);
    bus.IFPC = 32'hFFFF_FFFC;
    push("c32_wrap", 1, 0, 0, 32'h54); tick();
    idle();
    push("c33_flush_wrap", 1, 0, 1, 32'h0); tick();

    // Correct predictions, then a non-branch code that must not count
    br(3'b000, 32'h30, 13'h0004, 32'h9, 32'h9, 1'b1);
    bus.IFPC = 32'h30;
    push("c34_ok", 1, 0, 0, 32'h0); tick();
    push("c35_ok", 1, 1, 0, 32'h0); tick();
    push("c36_ok", 1, 1, 0, 32'h0); tick();
    br(3'b010, 32'h30, 13'h0004, 32'h9, 32'h9, 1'b1);
    push("c37_f010", 1, 1, 0, 32'h0); tick();
    idle();
    push("c38_stats", 1, 1, 0, 32'h0, 1, 32'd5, 32'd2); tick();

    repeat (2) @(negedge CLK);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/PC width.
REQ-002 SHALL have parameter BHT_ENTRIES, default 16, meaning number of 2-bit counters; power of two, 4..256.
REQ-003 SHALL have parameter CTR_INIT, default 2'b01, meaning counter reset value (weakly not-taken).
REQ-004 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port IFPC  input  XLEN  fetch PC for lookup.
REQ-007 SHALL have port PredTaken  output  1  prediction for IFPC.
REQ-008 SHALL have port DEBE  input  1  branch in DE valid for resolution.
REQ-009 SHALL have port DEStall  input  1  DE held; resolution suppressed.
REQ-010 SHALL have port DEBS  input  3  branch funct3.
REQ-011 SHALL have port DEPC  input  XLEN  PC of branch in DE.
REQ-012 SHALL have port DEImm  input  13  signed byte offset, bit 0 ignored.
REQ-013 SHALL have ports RRS1, RRS2  input  XLEN  operands.
REQ-014 SHALL have port DEPredTaken  input  1  prediction carried with the branch.
REQ-015 SHALL have port DEBranchFlush  output  1  registered mispredict flush.
REQ-016 SHALL have port RedirectPC  output  XLEN  registered corrected PC, valid when DEBranchFlush=1.

Function
REQ-017 SHALL index the table with PC[log2(BHT_ENTRIES)+1:2]; PredTaken = bit 1 of counter at IFPC index, combinational.
REQ-018 SHALL resolve, when DEBE=1, DEStall=0, DEBranchFlush=0: DEBS 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE.
REQ-019 SHALL treat DEBS 010/011 as not-taken with no counter update and no flush.
REQ-020 SHALL compute target = DEPC + sign-extended DEImm (bit 0 forced 0), modulo 2^XLEN; fall-through = DEPC + 4, modulo 2^XLEN.
REQ-021 SHALL, on a resolved branch, update the counter at DEPC index at that clock edge: taken saturating increment (max 11), not-taken saturating decrement (min 00).
REQ-022 SHALL, when outcome != DEPredTaken, assert DEBranchFlush for exactly the next cycle with RedirectPC = target (taken) or fall-through (not-taken); otherwise DEBranchFlush=0.
REQ-023 SHALL ignore DEBE in any cycle where DEBranchFlush=1 (wrong-path instruction): no update, no flush, hence no back-to-back flushes.
REQ-024 SHALL, when lookup and update hit the same index in one cycle, return the pre-update value on PredTaken (read-before-write).
REQ-025 SHALL hold RedirectPC at its last value when DEBranchFlush=0.
REQ-026 SHALL perform no update and no flush while DEStall=1; resolution happens in the first cycle DEStall=0.

Reset
REQ-027 SHALL, on rst_n=0 at any time, immediately set every counter to CTR_INIT, DEBranchFlush=0, RedirectPC=0, statistics counters=0.
REQ-028 SHALL discard a pending flush when reset asserts mid-operation; first resolution is possible on the first rising edge after rst_n=1.

Configuration
REQ-029 SHALL, with macro BPU_STATS_EN defined, add outputs BrCount and MissCount (32 bits each) counting resolved branches and mispredicts, saturating at 32'hFFFFFFFF.
REQ-030 SHALL, without BPU_STATS_EN, omit those ports and counters; all other behaviour identical.

Verification
REQ-031 SHALL cover: reset, IFPC=4 -> PredTaken=0; DEBE=1, DEBS=000, RRS1=RRS2=32'h10, DEPC=4, DEImm=-8, DEPredTaken=0 -> next cycle DEBranchFlush=1, RedirectPC=32'hFFFFFFFC.
REQ-032 SHALL cover: same branch resolved taken twice more (flush cycles skipped per REQ-023) -> counter at index 1 = 11, PredTaken=1 for IFPC=4; one not-taken -> 10, PredTaken still 1.
REQ-033 SHALL cover: DEBS=100, RRS1=32'hFFFFFFFF, RRS2=1 -> taken; DEBS=110 same operands -> not-taken; DEPredTaken=1 -> flush, RedirectPC=DEPC+4.
REQ-034 SHALL cover: mispredicting branch with DEStall=1 for 3 cycles -> no flush, no update; flush one cycle after DEStall falls.
REQ-035 SHALL cover: flush cycle with DEBE=1 mispredicting -> ignored; rst_n=0 during flush cycle -> DEBranchFlush=0 immediately, counters = CTR_INIT.
REQ-036 SHALL cover, with BPU_STATS_EN: 5 resolved branches, 2 mispredicts -> BrCount=5, MissCount=2; DEBS=010 -> neither increments.
